// File: rtl/motor_cmd_uart_master_if.sv
// Host/UART signal bundle for the motor command master.
interface motor_cmd_uart_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_idx;
  logic [15:0] cmd_divider;
  logic [10:0] cmd_steps;
  logic        cmd_dir;
  logic        cmd_err;
  logic        cmd_sent;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic [9:0]  pending;
  logic [9:0]  term_active;
  logic        status_valid;
  logic        status_err;

  modport master (
    input  cmd_valid, cmd_idx, cmd_divider, cmd_steps, cmd_dir,
    input  tx_busy, rx_valid, rx_data,
    output cmd_ready, cmd_err, cmd_sent, tx_start, tx_data,
    output pending, term_active, status_valid, status_err
  );

  modport slave (
    output cmd_valid, cmd_idx, cmd_divider, cmd_steps, cmd_dir,
    output tx_busy, rx_valid, rx_data,
    input  cmd_ready, cmd_err, cmd_sent, tx_start, tx_data,
    input  pending, term_active, status_valid, status_err
  );
endinterface

// File: rtl/motor_cmd_uart_master.sv
// Host-side motor command master: polls CPLD status over a byte UART
// and forwards 5-byte move packets once the target motor is idle.
module motor_cmd_uart_master #(
  parameter int unsigned GAP_CYCLES    = 4095,
  parameter int unsigned POLL_INTERVAL = 65535,
  parameter int unsigned REPLY_TIMEOUT = 131071
) (
  input  logic CLK,
  input  logic reset,
  motor_cmd_uart_master_if.master bus
);

  localparam int GW = $clog2(GAP_CYCLES + 2);
  localparam int PW = $clog2(POLL_INTERVAL + 2);
  localparam int RW = $clog2(REPLY_TIMEOUT + 2);

  typedef enum logic [2:0] {
    IDLE, Q_SEND, Q_WAIT, DECIDE, C_SEND
  } state_t;

  state_t        state, state_n;
  logic [GW-1:0] gap;
  logic [PW-1:0] poll;
  logic [RW-1:0] rtmr;
  logic [1:0]    rcnt;
  logic [2:0]    bcnt;
  logic [4:0]    sh0, sh1, sh2;
  logic          latched;
  logic [31:0]   word;
  logic [9:0]    pend, term;
  logic          txs;
  logic [7:0]    txd;
  logic          err_p, sent_p, sv_p, se_p;

  logic       can_tx, accept, rx_ok;
  logic       send, take, bad_cmd, rx_take;
  logic       q_done, q_fail, last;
  logic [7:0] byte_n, pick;

  assign bus.cmd_ready    = (state == IDLE) && !latched && !reset;
  assign bus.cmd_err      = err_p;
  assign bus.cmd_sent     = sent_p;
  assign bus.tx_start     = txs;
  assign bus.tx_data      = txd;
  assign bus.pending      = pend;
  assign bus.term_active  = term;
  assign bus.status_valid = sv_p;
  assign bus.status_err   = se_p;

  always_comb begin
    can_tx  = (gap == '0) && !bus.tx_busy;
    accept  = bus.cmd_valid && bus.cmd_ready;
    rx_ok   = (bus.rx_data[7:6] == rcnt) && !bus.rx_data[5];
    state_n = state;
    send    = 1'b0;
    take    = 1'b0;
    bad_cmd = 1'b0;
    rx_take = 1'b0;
    q_done  = 1'b0;
    q_fail  = 1'b0;
    last    = 1'b0;
    byte_n  = 8'h00;
    pick    = 8'h00;
    case (bcnt)
      3'd0:    pick = word[7:0];
      3'd1:    pick = word[15:8];
      3'd2:    pick = word[23:16];
      3'd3:    pick = word[31:24];
      default: pick = 8'h00;
    endcase
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (bus.cmd_idx > 4'd9) begin
            bad_cmd = 1'b1;
          end else begin
            take    = 1'b1;
            state_n = Q_SEND;
          end
        end else if (poll == '0) begin
          state_n = Q_SEND;
        end
      end
      Q_SEND: begin
        if (can_tx) begin
          send    = 1'b1;
          byte_n  = 8'h0F;
          state_n = Q_WAIT;
        end
      end
      Q_WAIT: begin
        if (bus.rx_valid) begin
          if (!rx_ok) begin
            q_fail  = 1'b1;
            state_n = IDLE;
          end else begin
            rx_take = 1'b1;
            if (rcnt == 2'd3) begin
              q_done  = 1'b1;
              state_n = DECIDE;
            end
          end
        end else if (rtmr == '0) begin
          q_fail  = 1'b1;
          state_n = IDLE;
        end
      end
      DECIDE: begin
        if (latched && !pend[word[3:0]])
          state_n = C_SEND;
        else
          state_n = IDLE;
      end
      C_SEND: begin
        if (can_tx) begin
          send   = 1'b1;
          byte_n = pick;
          if (bcnt == 3'd4) begin
            last    = 1'b1;
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      gap     <= '0;
      poll    <= PW'(POLL_INTERVAL);
      rtmr    <= '0;
      rcnt    <= '0;
      bcnt    <= '0;
      sh0     <= '0;
      sh1     <= '0;
      sh2     <= '0;
      latched <= 1'b0;
      word    <= '0;
      pend    <= 10'h3FF;
      term    <= '0;
      txs     <= 1'b0;
      txd     <= 8'h00;
      err_p   <= 1'b0;
      sent_p  <= 1'b0;
      sv_p    <= 1'b0;
      se_p    <= 1'b0;
    end else begin
      txs    <= send;
      err_p  <= bad_cmd;
      sent_p <= last;
      sv_p   <= q_done;
      se_p   <= q_fail;
      if (send) begin
        txd <= byte_n;
        gap <= GW'(GAP_CYCLES);
      end else if (gap != '0) begin
        gap <= gap - GW'(1);
      end
      // every return to IDLE starts a fresh poll interval
      if (state != IDLE)
        poll <= PW'(POLL_INTERVAL);
      else if (poll != '0)
        poll <= poll - PW'(1);
      if (take) begin
        latched <= 1'b1;
        word    <= {bus.cmd_dir, bus.cmd_steps,
                    bus.cmd_divider, bus.cmd_idx};
      end
      if (state == Q_SEND && send) begin
        rcnt <= '0;
        rtmr <= RW'(REPLY_TIMEOUT);
      end else if (state == Q_WAIT && rtmr != '0) begin
        rtmr <= rtmr - RW'(1);
      end
      if (rx_take) begin
        rcnt <= rcnt + 2'd1;
        case (rcnt)
          2'd0:    sh0 <= bus.rx_data[4:0];
          2'd1:    sh1 <= bus.rx_data[4:0];
          2'd2:    sh2 <= bus.rx_data[4:0];
          default: ;
        endcase
      end
      if (q_done) begin
        pend <= {sh1, sh0};
        term <= {bus.rx_data[4:0], sh2};
      end
      if (state == DECIDE)
        bcnt <= '0;
      else if (state == C_SEND && send)
        bcnt <= bcnt + 3'd1;
      if (last) begin
        pend[word[3:0]] <= 1'b1;
        latched         <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_motor_cmd_uart_master.sv
// Directed bench for motor_cmd_uart_master with shortened timers.
module tb_motor_cmd_uart_master;
  localparam int G = 7;
  localparam int P = 63;
  localparam int R = 255;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  motor_cmd_uart_master_if bus();

  motor_cmd_uart_master #(
    .GAP_CYCLES(G), .POLL_INTERVAL(P), .REPLY_TIMEOUT(R)
  ) dut (
    .CLK(clk), .reset(reset), .bus(bus)
  );

  typedef struct {
    logic [31:0] b;
    logic        good;
    logic [9:0]  pend;
    logic [9:0]  term;
  } rvec_t;

  typedef struct {
    logic [3:0]  idx;
    logic [15:0] dv;
    logic [10:0] st;
    logic        dr;
    logic [39:0] pkt;
  } cvec_t;

  typedef struct {
    int         c;
    logic [7:0] d;
  } tx_t;

  tx_t txq[$];
  int  checks = 0;
  int  failures = 0;
  int  cyc = 0;
  int  sv_cnt = 0, se_cnt = 0, ce_cnt = 0, cs_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.tx_start) txq.push_back('{cyc, bus.tx_data});
    if (bus.status_valid) sv_cnt <= sv_cnt + 1;
    if (bus.status_err) se_cnt <= se_cnt + 1;
    if (bus.cmd_err) ce_cnt <= ce_cnt + 1;
    if (bus.cmd_sent) cs_cnt <= cs_cnt + 1;
  end

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic expect_tx(input string nm, input logic [7:0] exp,
                           input int budget, output int c);
    int  n;
    tx_t t;
    n = 0;
    c = cyc;
    while (txq.size() == 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (txq.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s got=none exp=%h", nm, exp);
    end else begin
      t = txq.pop_front();
      c = t.c;
      chk(nm, 32'(t.d), 32'(exp));
    end
  endtask

  task automatic send_reply(input logic [31:0] b, input int nb);
    for (int k = 0; k < nb; k++) begin
      bus.rx_valid = 1'b1;
      bus.rx_data  = b[8*k +: 8];
      @(negedge clk);
      bus.rx_valid = 1'b0;
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic issue_cmd(input string nm, input logic [3:0] idx,
                           input logic [15:0] dv, input logic [10:0] st,
                           input logic dr);
    int n;
    n = 0;
    while (bus.cmd_ready !== 1'b1 && n < 4 * P) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_ready"}, 32'(bus.cmd_ready), 32'd1);
    bus.cmd_idx     = idx;
    bus.cmd_divider = dv;
    bus.cmd_steps   = st;
    bus.cmd_dir     = dr;
    bus.cmd_valid   = 1'b1;
    @(negedge clk);
    bus.cmd_valid   = 1'b0;
  endtask

  task automatic expect_packet(input string nm, input logic [39:0] pkt,
                               input int qc);
    int pc, c;
    pc = qc;
    for (int k = 0; k < 5; k++) begin
      expect_tx($sformatf("%s_b%0d", nm, k), pkt[8*k +: 8], G + 20, c);
      chk($sformatf("%s_gap%0d", nm, k), 32'((c - pc) >= G + 1), 32'd1);
      pc = c;
    end
  endtask

  task automatic reply_round(input rvec_t v, input int i, output int qc);
    int sv0, se0;
    sv0 = sv_cnt;
    se0 = se_cnt;
    expect_tx($sformatf("poll%0d_q", i), 8'h0F, P + 20, qc);
    send_reply(v.b, 4);
    repeat (2) @(negedge clk);
    chk($sformatf("poll%0d_valid", i), 32'(sv_cnt - sv0), 32'(v.good));
    chk($sformatf("poll%0d_err", i), 32'(se_cnt - se0), 32'(!v.good));
    chk($sformatf("poll%0d_pend", i), 32'(bus.pending), 32'(v.pend));
    chk($sformatf("poll%0d_term", i), 32'(bus.term_active), 32'(v.term));
  endtask

  task automatic run_cmd(input cvec_t v, input int i);
    int qc, cs0;
    string nm;
    nm  = $sformatf("cmd%0d", i);
    cs0 = cs_cnt;
    issue_cmd(nm, v.idx, v.dv, v.st, v.dr);
    expect_tx({nm, "_q"}, 8'h0F, G + 10, qc);
    send_reply(32'hC0804000, 4);
    expect_packet(nm, v.pkt, qc);
    repeat (2) @(negedge clk);
    chk({nm, "_sent"}, 32'(cs_cnt - cs0), 32'd1);
    chk({nm, "_pend"}, 32'(bus.pending), 32'd1 << v.idx);
  endtask

  rvec_t rv [6];
  cvec_t cv [3];

  initial begin
    int c0, qc, c, sv0, se0, ce0, cs0;

    rv[0] = '{32'hDF804005, 1'b1, 10'h005, 10'h3E0};
    rv[1] = '{32'hC0808000, 1'b0, 10'h005, 10'h3E0};
    rv[2] = '{32'hC0805F1F, 1'b1, 10'h3FF, 10'h000};
    rv[3] = '{32'hEC93550A, 1'b0, 10'h3FF, 10'h000};
    rv[4] = '{32'hCC93550A, 1'b1, 10'h2AA, 10'h193};
    rv[5] = '{32'hC0804000, 1'b1, 10'h000, 10'h000};

    cv[0] = '{4'd3, 16'h1234, 11'h0AB, 1'b1, 40'h008AB12343};
    cv[1] = '{4'd0, 16'hFFFF, 11'h7FF, 1'b0, 40'h007FFFFFF0};
    cv[2] = '{4'd9, 16'h0001, 11'h001, 1'b1, 40'h0080100019};

    reset           = 1'b1;
    bus.cmd_valid   = 1'b0;
    bus.cmd_idx     = '0;
    bus.cmd_divider = '0;
    bus.cmd_steps   = '0;
    bus.cmd_dir     = 1'b0;
    bus.tx_busy     = 1'b0;
    bus.rx_valid    = 1'b0;
    bus.rx_data     = '0;
    repeat (3) @(negedge clk);

    chk("rst_pend", 32'(bus.pending), 32'h3FF);
    chk("rst_term", 32'(bus.term_active), 32'h0);
    chk("rst_ready", 32'(bus.cmd_ready), 32'd0);
    chk("rst_txstart", 32'(bus.tx_start), 32'd0);
    chk("rst_txdata", 32'(bus.tx_data), 32'h0);
    chk("rst_sv", 32'(bus.status_valid), 32'd0);
    chk("rst_cmderr", 32'(bus.cmd_err), 32'd0);

    reset = 1'b0;
    c0 = cyc;
    @(negedge clk);
    chk("idle_ready", 32'(bus.cmd_ready), 32'd1);

    for (int i = 0; i < 6; i++) begin
      reply_round(rv[i], i, qc);
      if (i == 0)
        chk("first_poll_time",
            32'((qc - c0) >= P + 1 && (qc - c0) <= P + 3), 32'd1);
    end

    ce0 = ce_cnt;
    issue_cmd("bad", 4'd12, 16'h0101, 11'h011, 1'b0);
    repeat (10) @(negedge clk);
    chk("bad_err", 32'(ce_cnt - ce0), 32'd1);
    chk("bad_no_tx", 32'(txq.size()), 32'd0);
    chk("bad_ready", 32'(bus.cmd_ready), 32'd1);

    for (int i = 0; i < 3; i++) run_cmd(cv[i], i);

    sv0 = sv_cnt;
    cs0 = cs_cnt;
    issue_cmd("blk", 4'd2, 16'h00A0, 11'h005, 1'b0);
    expect_tx("blk_q1", 8'h0F, G + 10, qc);
    send_reply(32'hC0804004, 4);
    repeat (30) @(negedge clk);
    chk("blk_sv", 32'(sv_cnt - sv0), 32'd1);
    chk("blk_pend", 32'(bus.pending), 32'h004);
    chk("blk_no_tx", 32'(txq.size()), 32'd0);
    chk("blk_ready", 32'(bus.cmd_ready), 32'd0);
    expect_tx("blk_q2", 8'h0F, P + 20, qc);
    send_reply(32'hC0804000, 4);
    expect_packet("blk", 40'h0000500A02, qc);
    repeat (2) @(negedge clk);
    chk("blk_sent", 32'(cs_cnt - cs0), 32'd1);
    chk("blk_pend2", 32'(bus.pending), 32'h004);

    sv0 = sv_cnt;
    bus.tx_busy = 1'b1;
    repeat (P + 200) @(negedge clk);
    chk("busy_no_tx", 32'(txq.size()), 32'd0);
    bus.tx_busy = 1'b0;
    expect_tx("busy_q", 8'h0F, 3, qc);
    send_reply(32'hC0804000, 4);
    repeat (2) @(negedge clk);
    chk("busy_sv", 32'(sv_cnt - sv0), 32'd1);

    sv0 = sv_cnt;
    se0 = se_cnt;
    expect_tx("tmo_q", 8'h0F, P + 20, qc);
    send_reply(32'h00804000, 3);
    while (cyc < qc + R - 20) @(negedge clk);
    chk("tmo_early", 32'(se_cnt - se0), 32'd0);
    while (cyc < qc + R + 10) @(negedge clk);
    chk("tmo_err", 32'(se_cnt - se0), 32'd1);
    chk("tmo_sv", 32'(sv_cnt - sv0), 32'd0);
    chk("tmo_pend", 32'(bus.pending), 32'h000);

    issue_cmd("rst", 4'd5, 16'h0000, 11'h000, 1'b0);
    expect_tx("rst_q", 8'h0F, G + 10, qc);
    send_reply(32'hC0804000, 4);
    expect_tx("rst_b0", 8'h05, G + 20, c);
    expect_tx("rst_b1", 8'h00, G + 20, c);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_txstart", 32'(bus.tx_start), 32'd0);
    chk("mid_pend", 32'(bus.pending), 32'h3FF);
    chk("mid_ready", 32'(bus.cmd_ready), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("post_ready", 32'(bus.cmd_ready), 32'd1);
    chk("post_pend", 32'(bus.pending), 32'h3FF);
    chk("post_term", 32'(bus.term_active), 32'h0);
    chk("post_txdata", 32'(bus.tx_data), 32'h0);
    repeat (5 * (G + 1) + 10) @(negedge clk);
    chk("post_no_tx", 32'(txq.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
